// File: rtl/serial_adder_pkg.sv
// serial_adder shared types: FSM state and counter sizing.
// Optional subtract mode is enabled by SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder start/busy/done handshake and operand/result bundle.
// Sub exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             Sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  modport master (
    output start, A, B, Cin,
`ifdef SERIAL_ADDER_SUB_EN
    output Sub,
`endif
    input  busy, done, Sum, Cout, Ovf
  );

  modport slave (
    input  start, A, B, Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  Sub,
`endif
    output busy, done, Sum, Cout, Ovf
  );
endinterface

// File: rtl/serial_adder_full_adder.sv
// One-bit combinational full adder, used as the serial bit slice.
// No configuration macros.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);
  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// SERIAL_ADDER_SUB_EN adds a Sub port for A - B.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);

  state_t           state, nxt;
  logic [WIDTH-1:0] a_sh, b_sh, ps;
  logic [WIDTH:0]   ps_ext;
  logic [CW-1:0]    cnt;
  logic             cy, fa_b, fa_s, fa_co;
  logic             last, accept;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_r;
  assign fa_b = sub_r ? ~b_sh[0] : b_sh[0];
`else
  assign fa_b = b_sh[0];
`endif

  full_adder u_fa (
    .A    (a_sh[0]),
    .B    (fa_b),
    .Cin  (cy),
    .Sum  (fa_s),
    .Cout (fa_co)
  );

  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = bus.start && (state != RUN);
  assign ps_ext = {fa_s, ps};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (bus.start) nxt = RUN;
      RUN:     if (last) nxt = DONE;
      DONE:    nxt = bus.start ? RUN : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      ps       <= '0;
      cy       <= 1'b0;
      cnt      <= '0;
      bus.Sum  <= '0;
      bus.Cout <= 1'b0;
      bus.Ovf  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_r    <= 1'b0;
`endif
    end else if (accept) begin
      a_sh  <= bus.A;
      b_sh  <= bus.B;
      cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_r <= bus.Sub;
      cy    <= bus.Sub ? 1'b1 : bus.Cin;
`else
      cy    <= bus.Cin;
`endif
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      ps   <= ps_ext[WIDTH:1];
      cy   <= fa_co;
      cnt  <= cnt + CW'(1);
      // ovf compares carry into the MSB (cy) with carry out of it
      if (last) begin
        bus.Sum  <= ps_ext[WIDTH:1];
        bus.Cout <= fa_co;
        bus.Ovf  <= cy ^ fa_co;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 directed and WIDTH=3 sweep.
// Subtract case runs only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   miscmp = 0;

  logic [9:0] q8[$];
  logic [4:0] q3[$];

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(3)) bus3 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus8.done && bus8.busy) chk("busy_done8", 1'b1, 1'b0);
    if (bus8.done) begin
      if (q8.size() == 0) chk("unexpected_done8", 1'b1, 1'b0);
      else chk("result8", {bus8.Cout, bus8.Ovf, bus8.Sum}, q8.pop_front());
    end
  end

  always @(negedge clk) begin
    if (bus3.done) begin
      if (q3.size() == 0) chk("unexpected_done3", 1'b1, 1'b0);
      else chk("result3", {bus3.Cout, bus3.Ovf, bus3.Sum}, q3.pop_front());
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic s);
    bus8.start = 1'b1;
    bus8.A = a;
    bus8.B = b;
    bus8.Cin = c;
`ifdef SERIAL_ADDER_SUB_EN
    bus8.Sub = s;
`else
    if (s) $display("note: sub requested without SERIAL_ADDER_SUB_EN");
`endif
  endtask

  task automatic wait_done8(input string nm);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus8.done) break;
    end
    chk(nm, bus8.done, 1'b1);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [9:0] exp);
    @(negedge clk);
    issue8(a, b, c, 1'b0);
    q8.push_back(exp);
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8("timeout8");
  endtask

  task automatic run3(input logic [2:0] a, input logic [2:0] b,
                      input logic c);
    logic [3:0] s;
    logic       c2;
    s  = {1'b0, a} + {1'b0, b} + {3'b0, c};
    c2 = ({1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b0, c}) > 3'd3;
    @(negedge clk);
    bus3.start = 1'b1;
    bus3.A = a;
    bus3.B = b;
    bus3.Cin = c;
    q3.push_back({s[3], c2 ^ s[3], s[2:0]});
    @(negedge clk);
    bus3.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus3.done) break;
    end
    chk("timeout3", bus3.done, 1'b1);
  endtask

  initial begin
    bus8.start = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Cin = 1'b0;
    bus3.start = 1'b0; bus3.A = '0; bus3.B = '0; bus3.Cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus8.Sub = 1'b0;
    bus3.Sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_state",
        {bus8.busy, bus8.done, bus8.Cout, bus8.Ovf, bus8.Sum}, 12'h0);
    rst = 1'b0;

    // 0xFF+0x01 with exact busy/done timing
    @(negedge clk);
    issue8(8'hFF, 8'h01, 1'b0, 1'b0);
    q8.push_back({1'b1, 1'b0, 8'h00});
    @(negedge clk);
    bus8.start = 1'b0;
    chk("busy_k", {bus8.busy, bus8.done}, 2'b10);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("busy_run", {bus8.busy, bus8.done}, 2'b10);
    end
    @(negedge clk);
    chk("done_k8", {bus8.busy, bus8.done}, 2'b01);
    @(negedge clk);
    chk("idle_after", {bus8.busy, bus8.done}, 2'b00);

    run8(8'h7F, 8'h01, 1'b0, {1'b0, 1'b1, 8'h80});
    run8(8'hFF, 8'hFF, 1'b1, {1'b1, 1'b0, 8'hFF});

    // ignored start mid-RUN, then start on the DONE cycle
    @(negedge clk);
    issue8(8'h12, 8'h34, 1'b0, 1'b0);
    q8.push_back({1'b0, 1'b0, 8'h46});
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    issue8(8'hAA, 8'h55, 1'b0, 1'b0);
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8("timeout_b2b1");
    issue8(8'h01, 8'h01, 1'b0, 1'b0);
    q8.push_back({1'b0, 1'b0, 8'h02});
    @(negedge clk);
    bus8.start = 1'b0;
    chk("b2b_busy", bus8.busy, 1'b1);
    wait_done8("timeout_b2b2");

    // reset three cycles into an operation
    @(negedge clk);
    issue8(8'h0F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs",
        {bus8.busy, bus8.done, bus8.Cout, bus8.Ovf, bus8.Sum}, 12'h0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done) chk("abort_no_done", 1'b1, 1'b0);
    end
    run8(8'h0F, 8'h01, 1'b0, {1'b0, 1'b0, 8'h10});

`ifdef SERIAL_ADDER_SUB_EN
    @(negedge clk);
    issue8(8'h05, 8'h07, 1'b0, 1'b1);
    q8.push_back({1'b0, 1'b0, 8'hFE});
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.Sub = 1'b0;
    wait_done8("timeout_sub");
`endif

    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 2; c++)
          run3(3'(a), 3'(b), 1'(c));

    repeat (3) @(negedge clk);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    chk("q3_drained", 64'(q3.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder. It adds two WIDTH-bit operands plus carry-in through a single registered full-adder cell, one bit per clock, LSB first, and returns Sum, Cout and a signed-overflow flag after WIDTH cycles. A start/busy/done handshake controls it. It is the sequential, width-generic successor to the combinational one-bit full adder, for area-constrained datapaths where latency is acceptable.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1..64.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when the block is idle or done.
- A  input  WIDTH  operand A; captured on the accepted start.
- B  input  WIDTH  operand B; captured on the accepted start.
- Cin  input  1  carry-in; captured on the accepted start.
- Sub  input  1  subtract mode; present only with SERIAL_ADDER_SUB_EN; captured on the accepted start.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse when Sum, Cout and Ovf update.
- Sum  output  WIDTH  result; holds its value until the next done.
- Cout  output  1  carry-out of the MSB.
- Ovf  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- States: IDLE, RUN, DONE. Encoding is internal.
- Start acceptance:
  - A start is accepted when start=1 and the state is IDLE or DONE.
  - On acceptance, A and B load into shift registers, the carry register loads Cin, the bit counter clears, and the state moves to RUN.
- RUN, one bit per cycle:
  - The cell adds a_sh[0], b_sh[0] and the carry register.
  - The sum bit shifts into the MSB of the partial-sum register; a_sh and b_sh shift right.
  - The carry register takes the cell's Cout.
  - The counter increments.
- When the counter reaches WIDTH-1, that cycle also:
  - copies the completed partial sum (including the current bit) into Sum;
  - copies the cell Cout into Cout;
  - sets Ovf to (carry register before the update) XOR (cell Cout);
  - moves the state to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - Without a start, the next state is IDLE.
  - With a start, the next operation is accepted; this gives back-to-back throughput of one result per WIDTH+1 cycles.
- start during RUN is ignored with no side effects. Operand inputs are don't-care outside the acceptance cycle.
- Sum, Cout and Ovf never show partial results; they change only on the cycle that enters DONE.
- Arithmetic is modulo 2^WIDTH. The full result is {Cout, Sum} = A + B + Cin.
- WIDTH=1 degenerates to a single RUN cycle; behaviour is otherwise identical.

## Timing
- Reset values: state IDLE; busy 0; done 0; Sum 0; Cout 0; Ovf 0. Internal shift registers, carry and counter are also 0.
- With start accepted at rising edge k:
  - busy=1 from edge k to edge k+WIDTH.
  - Results update and done=1 from edge k+WIDTH until edge k+WIDTH+1.
- Latency from the start edge to done is WIDTH cycles.
- busy is 0 in IDLE and DONE; done and busy are never high together.
- Asserting rst mid-operation aborts immediately. No done is produced and outputs return to their reset values.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - The Sub port exists and is captured with the operands.
  - When Sub=1, the cell sees ~b_sh[0] and the carry register loads 1; Cin is ignored. The result is A - B modulo 2^WIDTH.
  - Cout=1 means no borrow. Ovf is signed subtraction overflow.
- SERIAL_ADDER_SUB_EN undefined: the Sub port is absent and the block is add-only.

## Structure
- Shared package serial_adder_pkg holds:
  - the state typedef (IDLE/RUN/DONE);
  - a function that returns the counter width, $clog2(WIDTH) with a minimum of 1.
- Sub-module: full_adder, the existing one-bit cell (ports A, B, Cin, Sum, Cout), instantiated once as the serial bit slice.
- The top level holds the FSM, counter, shift registers and result registers.

## Test plan
Each case runs with WIDTH=8 unless stated.
- Overflow into the carry: A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1, Ovf=0. done pulses exactly 8 cycles after the start edge, and busy is high for those 8 cycles.
- Signed overflow: A=0x7F, B=0x01, Cin=0 -> Sum=0x80, Cout=0, Ovf=1.
- All ones with carry-in: A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Cout=1, Ovf=0.
- Back-to-back and ignored start:
  - Start 0x12+0x34, then pulse start with 0xAA+0x55 mid-RUN: the second start is ignored and the result is Sum=0x46.
  - A start on the DONE cycle with 0x01+0x01 is accepted and yields Sum=0x02.
- Reset mid-operation: assert rst 3 cycles into 0x0F+0x01 -> no done pulse, and all outputs read 0. A new start after release gives the correct result.
- Exhaustive and subtract checks:
  - For WIDTH=3, sweep all A, B, Cin and compare {Cout, Sum} against A+B+Cin.
  - With SERIAL_ADDER_SUB_EN, 0x05-0x07 -> Sum=0xFE, Cout=0.
